// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one external memory port between instruction fetch (read-only)
//   and data memory (read/write). One transaction is in flight at a time.
//   Data has priority, but fetch is forced through after STARVE_LIMIT
//   consecutive data grants taken while fetch was waiting.
//
// Ports
//   clk, reset                 clock, async active-high reset
//   core_enable                1 = new grants allowed
//   core_request               demand indicator (any req or transaction in flight)
//   if_req/if_addr             fetch request and word address
//   if_rdata/if_ack            fetch read data, 1-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata  data request, direction, address, write data
//   d_rdata/d_ack              data read data, 1-cycle completion pulse
//   err                        high with an ack when the transaction was aborted
//   memory_*                   external memory port
//
// Configuration
//   ARB_TIMEOUT_EN  when defined, a BUSY transaction with no memory_response for
//                   TIMEOUT_CYCLES cycles is aborted with err=1. When undefined,
//                   BUSY waits indefinitely and err is held 0.
//
// States
//   IDLE   | waiting for a request; grants when core_enable is set
//   BUSY_I | fetch read in flight on the memory port
//   BUSY_D | data read/write in flight on the memory port
//   DONE   | ack pulse cycle; no grant is made here
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_enable,
    output logic        core_request,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        err,
    output logic [31:0] memory_addr,
    output logic        memory_rden,
    output logic        memory_wren,
    output logic [31:0] memory_write_val,
    input  logic [31:0] memory_read_val,
    input  logic        memory_response
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("mem_port_arbiter: STARVE_LIMIT must be 1..15 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic [31:0] addr_q, addr_d;
    logic        rden_q, rden_d;
    logic        wren_q, wren_d;
    logic [31:0] wval_q, wval_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        if_ack_q, if_ack_d;
    logic        d_ack_q, d_ack_d;
    logic        err_q, err_d;
    logic        fetch_forced;

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_q, tmo_d;
`endif

    // Fetch overrides data priority only once the streak has saturated.
    assign fetch_forced = if_req && (streak_q == STREAK_MAX);

    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        addr_d     = addr_q;
        rden_d     = rden_q;
        wren_d     = wren_q;
        wval_d     = wval_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
        err_d      = 1'b0;
`ifdef ARB_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (core_enable && (if_req || d_req)) begin
`ifdef ARB_TIMEOUT_EN
                    tmo_d = 16'd0;
`endif
                    if (d_req && !fetch_forced) begin
                        addr_d  = d_addr;
                        rden_d  = !d_we;
                        wren_d  = d_we;
                        wval_d  = d_wdata;
                        state_d = BUSY_D;
                        if (!if_req) begin
                            streak_d = 4'd0;
                        end else if (streak_q != STREAK_MAX) begin
                            streak_d = streak_q + 4'd1;
                        end
                    end else begin
                        addr_d   = if_addr;
                        rden_d   = 1'b1;
                        wren_d   = 1'b0;
                        wval_d   = 32'd0;
                        streak_d = 4'd0;
                        state_d  = BUSY_I;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (memory_response) begin
                    rden_d  = 1'b0;
                    wren_d  = 1'b0;
                    state_d = DONE;
                    if (state_q == BUSY_I) begin
                        if_rdata_d = memory_read_val;
                        if_ack_d   = 1'b1;
                    end else begin
                        // A write leaves the last read data untouched.
                        if (!wren_q) begin
                            d_rdata_d = memory_read_val;
                        end
                        d_ack_d = 1'b1;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_q == TIMEOUT_LAST) begin
                    rden_d  = 1'b0;
                    wren_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                    if (state_q == BUSY_I) begin
                        if_rdata_d = 32'd0;
                        if_ack_d   = 1'b1;
                    end else begin
                        d_rdata_d = 32'd0;
                        d_ack_d   = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            streak_q   <= 4'd0;
            addr_q     <= 32'd0;
            rden_q     <= 1'b0;
            wren_q     <= 1'b0;
            wval_q     <= 32'd0;
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 32'd0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            addr_q     <= addr_d;
            rden_q     <= rden_d;
            wren_q     <= wren_d;
            wval_q     <= wval_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            err_q      <= err_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= 16'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign core_request     = if_req || d_req || (state_q != IDLE);
    assign memory_addr      = addr_q;
    assign memory_rden      = rden_q;
    assign memory_wren      = wren_q;
    assign memory_write_val = wval_q;
    assign if_rdata         = if_rdata_q;
    assign d_rdata          = d_rdata_q;
    assign if_ack           = if_ack_q;
    assign d_ack            = d_ack_q;
    assign err              = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch read, data read/write,
// fetch-starvation ordering, core_enable gating, async reset mid-transaction,
// and (with ARB_TIMEOUT_EN) timeout abort vs. last-cycle response.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_enable;
    logic        core_request;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        err;
    logic [31:0] memory_addr;
    logic        memory_rden;
    logic        memory_wren;
    logic [31:0] memory_write_val;
    logic [31:0] memory_read_val;
    logic        memory_response;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .STARVE_LIMIT   (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .core_enable      (core_enable),
        .core_request     (core_request),
        .if_req           (if_req),
        .if_addr          (if_addr),
        .if_rdata         (if_rdata),
        .if_ack           (if_ack),
        .d_req            (d_req),
        .d_we             (d_we),
        .d_addr           (d_addr),
        .d_wdata          (d_wdata),
        .d_rdata          (d_rdata),
        .d_ack            (d_ack),
        .err              (err),
        .memory_addr      (memory_addr),
        .memory_rden      (memory_rden),
        .memory_wren      (memory_wren),
        .memory_write_val (memory_write_val),
        .memory_read_val  (memory_read_val),
        .memory_response  (memory_response)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Waits for a strobe at a negedge; an expired bound counts as a failure.
    task automatic wait_strobe(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (memory_rden || memory_wren) begin
                ok = 1'b1;
                return;
            end
        end
        check_val({tag, "_strobe_timeout"}, 32'd0, 32'd1);
    endtask

    // Data transaction, req raised at a negedge in IDLE; strobes held lat cycles.
    task automatic data_txn(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input int lat, input logic [31:0] rv);
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = addr;
        d_wdata = wdata;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            check_val({tag, "_rden"}, {31'd0, memory_rden}, {31'd0, !we});
            check_val({tag, "_wren"}, {31'd0, memory_wren}, {31'd0, we});
            check_val({tag, "_addr"}, memory_addr, addr);
            if (we) check_val({tag, "_wval"}, memory_write_val, wdata);
            if (c == lat) begin
                memory_response = 1'b1;
                memory_read_val = rv;
            end
        end
        @(negedge clk);
        memory_response = 1'b0;
        d_req = 1'b0;
        check_val({tag, "_ack"}, {31'd0, d_ack}, 32'd1);
        check_val({tag, "_err"}, {31'd0, err}, 32'd0);
        check_val({tag, "_strobes_off"}, {30'd0, memory_rden, memory_wren}, 32'd0);
    endtask

    logic [31:0] saved_rdata;
    logic [9:0]  exp_order;
    bit          ok;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        core_enable = 1'b1;
        if_req = 1'b0;
        if_addr = 32'd0;
        d_req = 1'b0;
        d_we = 1'b0;
        d_addr = 32'd0;
        d_wdata = 32'd0;
        memory_read_val = 32'd0;
        memory_response = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        @(negedge clk);
        check_val("rst_rden", {31'd0, memory_rden}, 32'd0);
        check_val("rst_wren", {31'd0, memory_wren}, 32'd0);
        check_val("rst_acks", {29'd0, if_ack, d_ack, err}, 32'd0);
        check_val("rst_core_request", {31'd0, core_request}, 32'd0);

        // Fetch read, response after 3 strobe cycles.
        if_req = 1'b1;
        if_addr = 32'h10;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check_val("if_rden", {31'd0, memory_rden}, 32'd1);
            check_val("if_wren", {31'd0, memory_wren}, 32'd0);
            check_val("if_addr", memory_addr, 32'h10);
            check_val("if_no_ack", {31'd0, if_ack}, 32'd0);
            if (c == 3) begin
                memory_response = 1'b1;
                memory_read_val = 32'hCAFE_0001;
            end
        end
        @(negedge clk);
        memory_response = 1'b0;
        if_req = 1'b0;
        check_val("if_ack", {31'd0, if_ack}, 32'd1);
        check_val("if_rdata", if_rdata, 32'hCAFE_0001);
        check_val("if_rden_off", {31'd0, memory_rden}, 32'd0);
        check_val("if_d_ack", {31'd0, d_ack}, 32'd0);
        @(negedge clk);
        check_val("if_ack_pulse", {31'd0, if_ack}, 32'd0);

        // Data read, then a write that must not disturb d_rdata.
        data_txn("drd", 1'b0, 32'h44, 32'd0, 1, 32'hBEEF_0002);
        check_val("drd_rdata", d_rdata, 32'hBEEF_0002);
        @(negedge clk);
        data_txn("dwr", 1'b1, 32'h40, 32'h1234_5678, 2, 32'hDEAD_DEAD);
        check_val("dwr_rdata_kept", d_rdata, 32'hBEEF_0002);
        @(negedge clk);
        check_val("dwr_ack_pulse", {31'd0, d_ack}, 32'd0);

        // Contention: both held high, immediate responses.
        exp_order = 10'b0111101111; // bit i = 1 for data grant i
        if_addr = 32'h100;
        d_addr  = 32'h200;
        d_we    = 1'b0;
        if_req  = 1'b1;
        d_req   = 1'b1;
        for (int g = 0; g < 10; g++) begin
            wait_strobe("cont", ok);
            if (!ok) break;
            check_val($sformatf("cont_grant%0d", g), {31'd0, memory_addr == 32'h200},
                      {31'd0, exp_order[g]});
            memory_response = 1'b1;
            memory_read_val = 32'h5000 + g;
            @(negedge clk);
            memory_response = 1'b0;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);

        // core_enable gating.
        core_enable = 1'b0;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h80;
        repeat (3) @(negedge clk);
        check_val("ce_no_strobe", {30'd0, memory_rden, memory_wren}, 32'd0);
        check_val("ce_core_request", {31'd0, core_request}, 32'd1);
        core_enable = 1'b1;
        @(negedge clk);
        check_val("ce_grant", {31'd0, memory_rden}, 32'd1);
        core_enable = 1'b0;
        @(negedge clk);
        check_val("ce_busy_hold", {31'd0, memory_rden}, 32'd1);
        memory_response = 1'b1;
        memory_read_val = 32'h0000_0A0A;
        @(negedge clk);
        memory_response = 1'b0;
        d_req = 1'b0;
        check_val("ce_ack", {31'd0, d_ack}, 32'd1);
        check_val("ce_rdata", d_rdata, 32'h0000_0A0A);
        core_enable = 1'b1;
        @(negedge clk);

        // Async reset during BUSY_D.
        d_req  = 1'b1;
        d_we   = 1'b1;
        d_addr = 32'hC0;
        d_wdata = 32'h0000_7777;
        wait_strobe("rst", ok);
        check_val("rst_busy_wren", {31'd0, memory_wren}, 32'd1);
        d_req = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check_val("rst_async_strobes", {30'd0, memory_rden, memory_wren}, 32'd0);
        check_val("rst_async_acks", {29'd0, if_ack, d_ack, err}, 32'd0);
        check_val("rst_async_core_request", {31'd0, core_request}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        memory_response = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_val("rst_no_ack", {30'd0, if_ack, d_ack}, 32'd0);
            check_val("rst_stay_idle", {31'd0, memory_rden}, 32'd0);
        end
        memory_response = 1'b0;

`ifdef ARB_TIMEOUT_EN
        // No response: abort after 8 BUSY cycles.
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'hE0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check_val("tmo_rden", {31'd0, memory_rden}, 32'd1);
            check_val("tmo_no_ack", {31'd0, d_ack}, 32'd0);
        end
        @(negedge clk);
        d_req = 1'b0;
        check_val("tmo_ack", {31'd0, d_ack}, 32'd1);
        check_val("tmo_err", {31'd0, err}, 32'd1);
        check_val("tmo_rdata", d_rdata, 32'd0);
        check_val("tmo_rden_off", {31'd0, memory_rden}, 32'd0);
        @(negedge clk);
        check_val("tmo_err_pulse", {31'd0, err}, 32'd0);
        // Response in the 8th cycle wins over the timeout.
        data_txn("tmo_edge", 1'b0, 32'hE4, 32'd0, 8, 32'h0000_0808);
        check_val("tmo_edge_rdata", d_rdata, 32'h0000_0808);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
